rob_commit: RTL and testbench
=============================

Name: rob_commit

Overview:
- In-order reorder buffer and commit stage placed directly downstream of the Tomasulo core's CDB broadcast.
- Issue allocates one entry per issued instruction, tagged with the reservation-station number it was assigned. CDB broadcasts mark matching entries complete and capture the result.
- Completed entries retire strictly in program order, one per cycle, producing the architectural register write and the commit PC trace.

Parameters:
- DEPTH, 8, number of ROB entries; power of two, 2..32.
- TAG_W, 8, width of the RS tag (matches the CDB rs_num width).
- XLEN, 32, data and PC width.

Ports:
- clk  in  1  main clock.
- rst  in  1  synchronous reset, active-low; asserted when 0.
- alloc_valid  in  1  issue stage presents an instruction.
- alloc_ready  out  1  entry is free; allocation fires on alloc_valid & alloc_ready.
- alloc_tag  in  TAG_W  RS entry number assigned at issue; must be nonzero.
- alloc_rd  in  5  destination register.
- alloc_wen  in  1  instruction writes rd; 0 for stores and branches.
- alloc_pc  in  XLEN  instruction PC.
- cdb_rs_num  in  TAG_W  CDB tag; 0 means idle.
- cdb_data  in  XLEN  CDB result.
- commit_valid  out  1  head entry is complete.
- commit_ready  in  1  register file accepts; commit fires on commit_valid & commit_ready.
- commit_rd  out  5  destination register.
- commit_wen  out  1  register-write qualifier (alloc_wen & rd!=0).
- commit_data  out  XLEN  result value.
- commit_pc  out  XLEN  retired PC.
- commit_tag  out  TAG_W  tag, so the RAT clears the mapping only if it still points at this tag.
- rob_count  out  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Storage is a circular buffer with head, tail and count registers. Each entry holds valid, done, tag, rd, wen, pc and data.
- Reset (rst==0 at posedge):
  - head=tail=count=0; all valid/done bits cleared.
  - Resulting outputs: alloc_ready=1, commit_valid=0, commit_rd/commit_wen/commit_data/commit_pc/commit_tag=0, rob_count=0.
  - Reset mid-operation discards all in-flight entries with no commit.
- alloc_ready = (count != DEPTH). A full buffer never accepts, even if a commit fires in the same cycle; this keeps combinational paths off the ready signal.
- Allocation:
  - On fire, write the entry at tail with valid=1 and done=0; tail advances with wrap (DEPTH-1 -> 0).
  - The new entry is visible to CDB matching from the next cycle. A CDB tag equal to alloc_tag in the allocation cycle belongs to an older instruction and must not mark the new entry.
- CDB capture:
  - When cdb_rs_num != 0, every entry with valid & !done & tag==cdb_rs_num sets done=1 and data=cdb_data at the posedge.
  - Invariant: at most one valid & !done entry per tag, because the RS entry stays busy until it broadcasts. Tag reuse by a younger instruction is legal once the older entry is done.
- Commit:
  - commit_valid = valid[head] & done[head]; commit_* are driven combinationally from the head entry, and are 0 when !commit_valid.
  - On fire: clear valid[head], head advances with wrap.
  - At most one commit per cycle; when commit_ready=0 the head entry holds.
- count: +1 on alloc fire only; -1 on commit fire only; unchanged when both or neither fire.
- Base commit latency: a CDB broadcast at cycle N makes the entry committable at N+1, provided it is the head.
- Simulation-only assertions:
  - alloc fire with alloc_tag==0;
  - alloc fire with a tag already held by a valid & !done entry;
  - a CDB tag with no matching incomplete entry, when the buffer is non-empty, is only a warning, since stale broadcasts are possible.

Optional Feature:
- Macro ROB_COMMIT_BYPASS_EN.
- Defined: if the head is valid & !done and cdb_rs_num matches its tag, then in the same cycle:
  - commit_valid=1;
  - commit_data=cdb_data (rd, pc and tag from the entry);
  - a fire retires the head directly without setting done.
  - Zero-cycle CDB-to-commit latency for the head.
- Undefined: no bypass; latency as above. Both builds give an identical commit order and identical data.

Decomposition:
- Shared package rob_pkg:
  - rob_entry_t struct (valid, done, tag, rd, wen, pc, data);
  - ROB_IDX_W derived from DEPTH;
  - TAG_NONE=0 constant, shared with the RS/CDB code.
- One sub-module, rob_tag_match: a DEPTH-wide comparator producing a one-hot hit vector from cdb_rs_num against the valid & !done tags. Reused later for RAT recovery.

Test Plan:
- Reset then idle -> alloc_ready=1, commit_valid=0, rob_count=0; hold rst=0 while alloc_valid=1 -> nothing allocated.
- Allocate tags 0x11 (pc 0x0), 0x12 (pc 0x4), 0x13 (pc 0x8); broadcast 0x13/0xC then 0x12/0xB then 0x11/0xA; commit_ready=1.
  - Commits in order with pc 0x0, 0x4, 0x8 and data 0xA, 0xB, 0xC.
  - The first commit is one cycle after the 0x11 broadcast (zero cycles with ROB_COMMIT_BYPASS_EN).
- Fill all 8 entries -> alloc_ready=0 and rob_count=8.
  - Complete the head and commit -> alloc_ready returns to 1 the next cycle.
  - Allocate 8 more -> the tail wraps, and the order is preserved across the wrap.
- Same-cycle alloc of tag 0x21 and CDB 0x21 for an older done-tag reuse -> the new entry stays !done; a later broadcast of 0x21/0x55 commits 0x55.
- Simultaneous alloc and commit with count=3 -> rob_count stays 3.
  - commit_ready=0 for 4 cycles with the head done -> commit_valid held at 1, head unchanged, no data loss.
- Entry with alloc_rd=0, alloc_wen=1 -> commit_wen=0; store with alloc_wen=0 -> commits with commit_wen=0 and advances the head.

Source files
------------

// File: rtl/rob_pkg.sv
// rob_pkg: shared types and constants for the reorder buffer / commit stage.
//   rob_entry_t : one ROB slot (valid, done, tag, rd, wen, pc, data)
//   ROB_IDX_W   : index width derived from ROB_DEPTH
//   TAG_NONE    : idle RS/CDB tag, shared with the RS and CDB code
package rob_pkg;
  localparam int ROB_DEPTH = 8;
  localparam int ROB_TAG_W = 8;
  localparam int ROB_XLEN  = 32;
  localparam int ROB_IDX_W = (ROB_DEPTH > 1) ? $clog2(ROB_DEPTH) : 1;

  localparam logic [ROB_TAG_W-1:0] TAG_NONE = '0;

  typedef struct packed {
    logic                valid;
    logic                done;
    logic [ROB_TAG_W-1:0] tag;
    logic [4:0]          rd;
    logic                wen;
    logic [ROB_XLEN-1:0] pc;
    logic [ROB_XLEN-1:0] data;
  } rob_entry_t;
endpackage

// File: rtl/rob_tag_match.sv
// rob_tag_match: DEPTH-wide tag comparator. Produces a one-hot hit vector of
// the open (valid & !done) entries whose tag equals tag_i. Tag 0 is the idle
// value and never hits.
//   tag_i  : tag to search for (CDB rs_num, or an issue/recovery tag)
//   open_i : per-entry valid & !done
//   tags_i : per-entry stored tag
//   hit_o  : per-entry match (at most one set while the RS invariant holds)
module rob_tag_match #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 8
) (
  input  logic [TAG_W-1:0]            tag_i,
  input  logic [DEPTH-1:0]            open_i,
  input  logic [DEPTH-1:0][TAG_W-1:0] tags_i,
  output logic [DEPTH-1:0]            hit_o
);
  for (genvar i = 0; i < DEPTH; i++) begin : g_lane
    assign hit_o[i] = open_i[i] & (|tag_i) & (tags_i[i] == tag_i);
  end
endmodule

// File: rtl/rob_commit.sv
// rob_commit: in-order reorder buffer and commit stage fed by the CDB.
// Issue allocates at the tail, CDB broadcasts complete entries by RS tag,
// and completed entries retire from the head one per cycle.
//   clk, rst            : clock, synchronous active-low reset
//   alloc_*             : issue-side allocation handshake and entry fields
//   cdb_rs_num/cdb_data : result broadcast (tag 0 = idle)
//   commit_*            : head-entry retirement handshake and fields
//   rob_count           : occupied entries
// Optional: define ROB_COMMIT_BYPASS_EN to let a CDB broadcast that hits the
// head retire it in the same cycle (zero-cycle CDB-to-commit latency).
// TAG_W and XLEN must match the widths rob_pkg uses for rob_entry_t.
module rob_commit
  import rob_pkg::*;
#(
  parameter int DEPTH = ROB_DEPTH,
  parameter int TAG_W = ROB_TAG_W,
  parameter int XLEN  = ROB_XLEN
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alloc_valid,
  output logic                       alloc_ready,
  input  logic [TAG_W-1:0]           alloc_tag,
  input  logic [4:0]                 alloc_rd,
  input  logic                       alloc_wen,
  input  logic [XLEN-1:0]            alloc_pc,
  input  logic [TAG_W-1:0]           cdb_rs_num,
  input  logic [XLEN-1:0]            cdb_data,
  output logic                       commit_valid,
  input  logic                       commit_ready,
  output logic [4:0]                 commit_rd,
  output logic                       commit_wen,
  output logic [XLEN-1:0]            commit_data,
  output logic [XLEN-1:0]            commit_pc,
  output logic [TAG_W-1:0]           commit_tag,
  output logic [$clog2(DEPTH):0]     rob_count
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  rob_entry_t       ent_q [DEPTH];
  rob_entry_t       ent_d [DEPTH];
  logic [IDX_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [DEPTH-1:0]            open;
  logic [DEPTH-1:0][TAG_W-1:0] tags;
  logic [DEPTH-1:0]            cdb_hit;
  rob_entry_t                  hd;
  logic                        byp, alloc_fire, commit_fire;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      open[i] = ent_q[i].valid & ~ent_q[i].done;
      tags[i] = ent_q[i].tag;
    end
  end

  rob_tag_match #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_cdb_match (
    .tag_i (cdb_rs_num),
    .open_i(open),
    .tags_i(tags),
    .hit_o (cdb_hit)
  );

  assign hd          = ent_q[head_q];
  assign alloc_ready = (count_q != CNT_W'(DEPTH));
  assign alloc_fire  = alloc_valid & alloc_ready;

`ifdef ROB_COMMIT_BYPASS_EN
  // A hit implies the head is valid & !done, so it can retire on the
  // broadcast value directly.
  assign byp = cdb_hit[head_q];
`else
  assign byp = 1'b0;
`endif

  assign commit_valid = hd.valid & (hd.done | byp);
  assign commit_fire  = commit_valid & commit_ready;

  always_comb begin
    commit_rd   = '0;
    commit_wen  = 1'b0;
    commit_data = '0;
    commit_pc   = '0;
    commit_tag  = '0;
    if (commit_valid) begin
      commit_rd   = hd.rd;
      commit_wen  = hd.wen & (hd.rd != 5'd0);
      commit_data = byp ? cdb_data : hd.data;
      commit_pc   = hd.pc;
      commit_tag  = hd.tag;
    end
  end

  always_comb begin
    ent_d   = ent_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (cdb_hit[i]) begin
        ent_d[i].done = 1'b1;
        ent_d[i].data = cdb_data;
      end
    end
    // Commit clears after the CDB update so a bypassed head leaves no
    // stale done bit behind.
    if (commit_fire) begin
      ent_d[head_q].valid = 1'b0;
      ent_d[head_q].done  = 1'b0;
      head_d              = head_q + 1'b1;
    end
    // The tail slot is free whenever alloc fires, so it cannot take a CDB
    // hit this cycle: a same-cycle matching tag belongs to an older entry.
    if (alloc_fire) begin
      ent_d[tail_q].valid = 1'b1;
      ent_d[tail_q].done  = 1'b0;
      ent_d[tail_q].tag   = alloc_tag;
      ent_d[tail_q].rd    = alloc_rd;
      ent_d[tail_q].wen   = alloc_wen;
      ent_d[tail_q].pc    = alloc_pc;
      ent_d[tail_q].data  = '0;
      tail_d              = tail_q + 1'b1;
    end
    if (alloc_fire && !commit_fire)      count_d = count_q + 1'b1;
    else if (!alloc_fire && commit_fire) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      ent_q   <= ent_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign rob_count = count_q;

`ifndef SYNTHESIS
  logic [DEPTH-1:0] alloc_hit;

  rob_tag_match #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_alloc_match (
    .tag_i (alloc_tag),
    .open_i(open),
    .tags_i(tags),
    .hit_o (alloc_hit)
  );

  // Reissue of a tag whose older holder broadcasts in this same cycle is
  // legal: the RS entry frees and is reassigned on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      assert (!(alloc_fire && alloc_tag == TAG_NONE))
        else $error("rob_commit: allocation with idle tag");
      assert (!(alloc_fire && (|alloc_hit) && cdb_rs_num != alloc_tag))
        else $error("rob_commit: allocation with tag %0h still in flight", alloc_tag);
      if (cdb_rs_num != TAG_NONE && count_q != '0 && !(|cdb_hit))
        $warning("rob_commit: stale CDB tag %0h", cdb_rs_num);
    end
  end
`endif
endmodule

// File: tb/tb_rob_commit.sv
// tb_rob_commit: directed bench for rob_commit. A vector table covers reset
// and the basic out-of-order-completion / in-order-commit case; hand-written
// sequences cover full/wrap, same-cycle tag reuse, simultaneous alloc and
// commit, back-pressure hold, rd=0 and store commits, and mid-run reset.
module tb_rob_commit;
  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_valid, alloc_ready, alloc_wen;
  logic [7:0]  alloc_tag, cdb_rs_num, commit_tag;
  logic [4:0]  alloc_rd, commit_rd;
  logic [31:0] alloc_pc, cdb_data, commit_data, commit_pc;
  logic        commit_valid, commit_ready, commit_wen;
  logic [3:0]  rob_count;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rob_commit #(.DEPTH(8), .TAG_W(8), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .alloc_rd(alloc_rd), .alloc_wen(alloc_wen), .alloc_pc(alloc_pc),
    .cdb_rs_num(cdb_rs_num), .cdb_data(cdb_data),
    .commit_valid(commit_valid), .commit_ready(commit_ready), .commit_rd(commit_rd),
    .commit_wen(commit_wen), .commit_data(commit_data), .commit_pc(commit_pc),
    .commit_tag(commit_tag), .rob_count(rob_count)
  );

  typedef struct {
    logic        rst, av;
    logic [7:0]  tag;
    logic [4:0]  rd;
    logic        wen;
    logic [31:0] pc;
    logic [7:0]  cdb;
    logic [31:0] cd;
    logic        cr;
    logic        e_ar, e_cv;
    logic [4:0]  e_rd;
    logic        e_wen;
    logic [31:0] e_data, e_pc;
    logic [7:0]  e_tag;
    logic [3:0]  e_cnt;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, av, input logic [7:0] tag, input logic [4:0] rd,
                     input logic wen, input logic [31:0] pc, input logic [7:0] cdb,
                     input logic [31:0] cd, input logic cr, input logic e_ar, e_cv,
                     input logic [4:0] e_rd, input logic e_wen, input logic [31:0] e_data,
                     input logic [31:0] e_pc, input logic [7:0] e_tag, input logic [3:0] e_cnt);
    vec_t v;
    v.rst = r; v.av = av; v.tag = tag; v.rd = rd; v.wen = wen; v.pc = pc;
    v.cdb = cdb; v.cd = cd; v.cr = cr; v.e_ar = e_ar; v.e_cv = e_cv;
    v.e_rd = e_rd; v.e_wen = e_wen; v.e_data = e_data; v.e_pc = e_pc;
    v.e_tag = e_tag; v.e_cnt = e_cnt;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_commit(input string nm, input logic cv, input logic [4:0] rd,
                            input logic wen, input logic [31:0] data, input logic [31:0] pc,
                            input logic [7:0] tag);
    chk(nm, {commit_valid, commit_rd, commit_wen, commit_data, commit_pc, commit_tag},
            {cv, rd, wen, data, pc, tag});
  endtask

  // Drive one cycle's inputs at the falling edge; outputs settle 1 time unit later.
  task automatic go(input logic av, input logic [7:0] tag, input logic [4:0] rd,
                    input logic wen, input logic [31:0] pc, input logic [7:0] cdb,
                    input logic [31:0] cd, input logic cr);
    @(negedge clk);
    rst = 1'b1; alloc_valid = av; alloc_tag = tag; alloc_rd = rd; alloc_wen = wen;
    alloc_pc = pc; cdb_rs_num = cdb; cdb_data = cd; commit_ready = cr;
    #1;
  endtask

  task automatic idle(input logic cr);
    go(1'b0, 8'h00, 5'd0, 1'b0, 32'h0, 8'h00, 32'h0, cr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; alloc_valid = 1'b1; alloc_tag = 8'h11; alloc_rd = 5'd1; alloc_wen = 1'b1;
    alloc_pc = '0; cdb_rs_num = '0; cdb_data = '0; commit_ready = 1'b0;

    // Reset (with alloc_valid high), then three allocations completed in reverse.
    add(0,1,8'h11,1,1,32'h0, 8'h00,32'h0,0, 1,0,0,0,32'h0,32'h0,8'h00,4'd0);
    add(0,0,8'h00,0,0,32'h0, 8'h00,32'h0,0, 1,0,0,0,32'h0,32'h0,8'h00,4'd0);
    add(1,1,8'h11,1,1,32'h0, 8'h00,32'h0,0, 1,0,0,0,32'h0,32'h0,8'h00,4'd0);
    add(1,1,8'h12,2,1,32'h4, 8'h00,32'h0,0, 1,0,0,0,32'h0,32'h0,8'h00,4'd1);
    add(1,1,8'h13,3,1,32'h8, 8'h00,32'h0,0, 1,0,0,0,32'h0,32'h0,8'h00,4'd2);
    add(1,0,8'h00,0,0,32'h0, 8'h13,32'hC,0, 1,0,0,0,32'h0,32'h0,8'h00,4'd3);
    add(1,0,8'h00,0,0,32'h0, 8'h12,32'hB,0, 1,0,0,0,32'h0,32'h0,8'h00,4'd3);
`ifdef ROB_COMMIT_BYPASS_EN
    add(1,0,8'h00,0,0,32'h0, 8'h11,32'hA,1, 1,1,1,1,32'hA,32'h0,8'h11,4'd3);
    add(1,0,8'h00,0,0,32'h0, 8'h00,32'h0,1, 1,1,2,1,32'hB,32'h4,8'h12,4'd2);
    add(1,0,8'h00,0,0,32'h0, 8'h00,32'h0,1, 1,1,3,1,32'hC,32'h8,8'h13,4'd1);
    add(1,0,8'h00,0,0,32'h0, 8'h00,32'h0,1, 1,0,0,0,32'h0,32'h0,8'h00,4'd0);
`else
    add(1,0,8'h00,0,0,32'h0, 8'h11,32'hA,1, 1,0,0,0,32'h0,32'h0,8'h00,4'd3);
    add(1,0,8'h00,0,0,32'h0, 8'h00,32'h0,1, 1,1,1,1,32'hA,32'h0,8'h11,4'd3);
    add(1,0,8'h00,0,0,32'h0, 8'h00,32'h0,1, 1,1,2,1,32'hB,32'h4,8'h12,4'd2);
    add(1,0,8'h00,0,0,32'h0, 8'h00,32'h0,1, 1,1,3,1,32'hC,32'h8,8'h13,4'd1);
`endif
    add(1,0,8'h00,0,0,32'h0, 8'h00,32'h0,1, 1,0,0,0,32'h0,32'h0,8'h00,4'd0);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      rst = vq[i].rst; alloc_valid = vq[i].av; alloc_tag = vq[i].tag; alloc_rd = vq[i].rd;
      alloc_wen = vq[i].wen; alloc_pc = vq[i].pc; cdb_rs_num = vq[i].cdb;
      cdb_data = vq[i].cd; commit_ready = vq[i].cr;
      #1;
      chk($sformatf("vec%0d", i),
          {alloc_ready, commit_valid, commit_rd, commit_wen, commit_data, commit_pc, commit_tag, rob_count},
          {vq[i].e_ar, vq[i].e_cv, vq[i].e_rd, vq[i].e_wen, vq[i].e_data, vq[i].e_pc, vq[i].e_tag, vq[i].e_cnt});
    end

    // Fill all 8 entries (head/tail start at 3, so the tail wraps).
    for (int k = 0; k < 8; k++) begin
      go(1'b1, 8'(32'h31 + k), 5'(k + 1), 1'b1, 32'h100 + 32'(4 * k), 8'h00, 32'h0, 1'b0);
      chk($sformatf("fill_cnt%0d", k), {alloc_ready, rob_count}, {1'b1, 4'(k)});
    end
    idle(1'b0);
    chk("full", {alloc_ready, rob_count}, {1'b0, 4'd8});
    go(1'b0, 8'h00, 5'd0, 1'b0, 32'h0, 8'h31, 32'h1000, 1'b0);
    // Commit while full with alloc_valid high: the allocation must not fire.
    go(1'b1, 8'h39, 5'd9, 1'b1, 32'h300, 8'h00, 32'h0, 1'b1);
    chk_commit("full_commit", 1'b1, 5'd1, 1'b1, 32'h1000, 32'h100, 8'h31);
    chk("full_no_ready", alloc_ready, 1'b0);
    idle(1'b0);
    chk("ready_back", {alloc_ready, rob_count}, {1'b1, 4'd7});
    for (int k = 1; k < 8; k++)
      go(1'b0, 8'h00, 5'd0, 1'b0, 32'h0, 8'(32'h31 + k), 32'h1000 + 32'(k), 1'b0);
    // Retire the old entries while refilling behind them.
    for (int k = 0; k < 7; k++) begin
      go(1'b1, 8'(32'h41 + k), 5'(k + 1), 1'b1, 32'h200 + 32'(4 * k), 8'h00, 32'h0, 1'b1);
      chk_commit($sformatf("drain_old%0d", k), 1'b1, 5'(k + 2), 1'b1, 32'h1000 + 32'(k + 1),
                 32'h100 + 32'(4 * (k + 1)), 8'(32'h32 + k));
      chk($sformatf("drain_cnt%0d", k), rob_count, 4'd7);
    end
    go(1'b1, 8'h48, 5'd8, 1'b1, 32'h21C, 8'h00, 32'h0, 1'b0);
    idle(1'b0);
    chk("refull", {alloc_ready, rob_count}, {1'b0, 4'd8});
    for (int k = 0; k < 8; k++)
      go(1'b0, 8'h00, 5'd0, 1'b0, 32'h0, 8'(32'h41 + k), 32'h2000 + 32'(k), 1'b0);
    for (int k = 0; k < 8; k++) begin
      idle(1'b1);
      chk_commit($sformatf("wrap_order%0d", k), 1'b1, 5'(k + 1), 1'b1, 32'h2000 + 32'(k),
                 32'h200 + 32'(4 * k), 8'(32'h41 + k));
    end
    idle(1'b0);
    chk("wrap_empty", {commit_valid, rob_count}, {1'b0, 4'd0});

    // Tag reuse: the older 0x21 completes in the cycle the younger 0x21 issues.
    go(1'b1, 8'h21, 5'd5, 1'b1, 32'h300, 8'h00, 32'h0, 1'b0);
    go(1'b1, 8'h21, 5'd6, 1'b1, 32'h304, 8'h21, 32'h44, 1'b0);
    idle(1'b1);
    chk_commit("reuse_old", 1'b1, 5'd5, 1'b1, 32'h44, 32'h300, 8'h21);
    idle(1'b1);
    chk_commit("reuse_new_open", 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 8'h00);
    chk("reuse_cnt", rob_count, 4'd1);
    go(1'b0, 8'h00, 5'd0, 1'b0, 32'h0, 8'h21, 32'h55, 1'b0);
    idle(1'b1);
    chk_commit("reuse_new", 1'b1, 5'd6, 1'b1, 32'h55, 32'h304, 8'h21);
    idle(1'b0);
    chk("reuse_empty", rob_count, 4'd0);

    // Back-pressure hold, then simultaneous alloc and commit at count 3.
    go(1'b1, 8'h51, 5'd1, 1'b1, 32'h400, 8'h00, 32'h0, 1'b0);
    go(1'b1, 8'h52, 5'd2, 1'b1, 32'h404, 8'h00, 32'h0, 1'b0);
    go(1'b1, 8'h53, 5'd3, 1'b1, 32'h408, 8'h00, 32'h0, 1'b0);
    go(1'b0, 8'h00, 5'd0, 1'b0, 32'h0, 8'h51, 32'h77, 1'b0);
    for (int k = 0; k < 4; k++) begin
      idle(1'b0);
      chk_commit($sformatf("hold%0d", k), 1'b1, 5'd1, 1'b1, 32'h77, 32'h400, 8'h51);
      chk($sformatf("hold_cnt%0d", k), rob_count, 4'd3);
    end
    go(1'b1, 8'h54, 5'd4, 1'b1, 32'h40C, 8'h00, 32'h0, 1'b1);
    chk_commit("simul_commit", 1'b1, 5'd1, 1'b1, 32'h77, 32'h400, 8'h51);
    idle(1'b0);
    chk("simul_cnt", {commit_valid, rob_count}, {1'b0, 4'd3});
    go(1'b0, 8'h00, 5'd0, 1'b0, 32'h0, 8'h52, 32'h78, 1'b0);
    go(1'b0, 8'h00, 5'd0, 1'b0, 32'h0, 8'h53, 32'h79, 1'b0);
    go(1'b0, 8'h00, 5'd0, 1'b0, 32'h0, 8'h54, 32'h7A, 1'b0);
    for (int k = 0; k < 3; k++) begin
      idle(1'b1);
      chk_commit($sformatf("simul_drain%0d", k), 1'b1, 5'(k + 2), 1'b1, 32'h78 + 32'(k),
                 32'h404 + 32'(4 * k), 8'(32'h52 + k));
    end

    // rd=0 with wen=1, then a store (wen=0).
    go(1'b1, 8'h61, 5'd0, 1'b1, 32'h500, 8'h00, 32'h0, 1'b0);
    go(1'b1, 8'h62, 5'd7, 1'b0, 32'h504, 8'h00, 32'h0, 1'b0);
    go(1'b0, 8'h00, 5'd0, 1'b0, 32'h0, 8'h61, 32'h99, 1'b0);
    go(1'b0, 8'h00, 5'd0, 1'b0, 32'h0, 8'h62, 32'h98, 1'b0);
    idle(1'b1);
    chk_commit("rd0", 1'b1, 5'd0, 1'b0, 32'h99, 32'h500, 8'h61);
    idle(1'b1);
    chk_commit("store", 1'b1, 5'd7, 1'b0, 32'h98, 32'h504, 8'h62);
    idle(1'b0);
    chk("store_adv", {commit_valid, rob_count}, {1'b0, 4'd0});

    // Reset with a completed entry in flight: it must vanish uncommitted.
    go(1'b1, 8'h71, 5'd3, 1'b1, 32'h600, 8'h00, 32'h0, 1'b0);
    go(1'b0, 8'h00, 5'd0, 1'b0, 32'h0, 8'h71, 32'h5A, 1'b0);
    @(negedge clk);
    rst = 1'b0; cdb_rs_num = '0; commit_ready = 1'b1;
    idle(1'b1);
    chk("midreset", {alloc_ready, commit_valid, rob_count}, {1'b1, 1'b0, 4'd0});
    chk_commit("midreset_out", 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
